// File: rtl/dmem_write_buffer_bridge.sv
// Posted-write buffer between the core data port and a req/ready/rvalid data memory.
// Latency: stores 0 cycles while buffer has room; load hit 0 cycles; load miss >= 3 stall cycles.
// Backpressure: stall holds the core on full buffer or load miss; memory side waits on mem_ready.
// Build option WBUF_FWD_EN: search the buffer on loads and forward the youngest matching store.
module dmem_write_buffer_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 7,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] buf_addr [DEPTH];
  logic [DW-1:0] buf_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt;
  logic [DW-1:0] rdata_q;
  logic          store, load, full, enq, deq, hit, rd_go;
  logic [DW-1:0] hit_data;
`ifdef WBUF_FWD_EN
  logic [PW-1:0] idx;
`endif

  // WEN=0 wins over OEN=0, so a write with both enables low is a store
  assign store = !CEN && !WEN;
  assign load  = !CEN && !OEN && WEN;
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign enq   = store && !full;

  // Buffer search: scan oldest to youngest so the last match seen is the youngest
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
`ifdef WBUF_FWD_EN
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < cnt) && (buf_addr[idx] == A)) begin
        hit      = 1'b1;
        hit_data = buf_data[idx];
      end
    end
`endif
  end

  // Next state, core stall, memory request and load data
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    ReadDataMem = '0;
    rd_go       = 1'b0;
    deq         = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
`ifdef WBUF_FWD_EN
          // a miss matches no buffered entry, so it may bypass pending stores
          rd_go = !hit;
`else
          // without a search, a load waits for the buffer to empty to keep ordering
          rd_go = (cnt == '0);
`endif
          if (hit) begin
            ReadDataMem = hit_data;
          end else begin
            stall = 1'b1;
            if (rd_go) state_nxt = RD_REQ;
          end
        end
        // drain the head entry unless a read is about to take the memory port
        if ((cnt != '0) && !rd_go) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = buf_addr[rd_ptr];
          mem_wdata = buf_data[rd_ptr];
          deq       = mem_ready;
        end
      end
      RD_REQ: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = A;
        if (mem_ready) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (mem_rvalid) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        ReadDataMem = rdata_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (store && full) stall = 1'b1;
  end

  // FSM, pointers, occupancy and captured read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      if ((state == RD_WAIT) && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

  // Entry storage needs no reset: occupancy decides which slots are live
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr[wr_ptr] <= A;
      buf_data[wr_ptr] <= Data2Mem;
    end
  end

endmodule

// File: tb/tb_dmem_write_buffer_bridge.sv
// Scoreboard bench for dmem_write_buffer_bridge: architectural memory model vs. core loads
// and memory write stream; directed latency / full / reset cases, then randomized traffic.
module tb_dmem_write_buffer_bridge;

  logic        clk, rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem, ReadDataMem;
  logic        stall, mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  dmem_write_buffer_bridge #(.DEPTH(4), .AW(7), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [6:0] a; logic [31:0] d; } wr_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         wq[$];          // stores in program order, awaiting memory write
  logic [31:0] lq[$];          // expected load results in program order
  logic [31:0] mem_arr [128];  // backing memory contents
  logic [31:0] arch    [128];  // architectural memory as the core sees it
  int          rdy_mode = 1;   // 0 ready low, 1 ready high, 2 random
  int          rv_delay = 1;
  bit          rv_rand  = 0;
  int          rv_cnt   = 0;
  logic [6:0]  rd_a;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: accepts at the edge after a negedge where req&&ready
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req && mem_ready) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else begin
          rd_a   = mem_addr;
          rv_cnt = rv_rand ? int'($urandom_range(1, 3)) : rv_delay;
        end
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_arr[rd_a];
        end
      end
      case (rdy_mode)
        0:       mem_ready = 1'b0;
        1:       mem_ready = 1'b1;
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops and compares whenever the DUT presents a transaction
  initial begin
    bit prev_pend, prev_we, load_now, wd_ok, clash;
    wr_t w;
    prev_pend = 0; prev_we = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 0;
        continue;
      end
      load_now = !CEN && !OEN && WEN;
      wd_ok = 0;
`ifdef WBUF_FWD_EN
      wd_ok = prev_we && load_now;
`endif
      if (prev_pend && !wd_ok) chk("req_held", mem_req, 1);
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          if (wq.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            w = wq.pop_front();
            chk("wr_addr", mem_addr, w.a);
            chk("wr_data", mem_wdata, w.d);
          end
        end else begin
          chk("rd_addr", mem_addr, A);
`ifdef WBUF_FWD_EN
          clash = 0;
          foreach (wq[i]) if (wq[i].a == mem_addr) clash = 1;
          chk("rd_bypass_safe", clash, 0);
`else
          chk("rd_after_drain", wq.size(), 0);
`endif
        end
      end
      if (load_now && !stall) begin
        if (lq.size() == 0) chk("unexpected_load_done", 1, 0);
        else chk("load_data", ReadDataMem, lq.pop_front());
      end
      if (CEN) chk("rdata_idle", ReadDataMem, 0);
      prev_pend = mem_req && !mem_ready;
      prev_we   = mem_we;
    end
  end

  task automatic drive_op(input bit st, input logic [6:0] a, input logic [31:0] d);
    CEN = 0; WEN = !st; OEN = st ? 1'($urandom_range(0, 1)) : 1'b0;
    A = a; Data2Mem = d;
    if (st) begin
      wq.push_back('{a, d});
      arch[a] = d;
    end else lq.push_back(arch[a]);
  endtask

  // Counts stall cycles until the op completes; returns at posedge+1 after it
  task automatic wait_done(output int ns);
    ns = 0;
    @(negedge clk);
    while (stall && ns < 100) begin
      ns++;
      @(negedge clk);
    end
    chk("op_done", stall, 0);
    @(posedge clk); #1;
  endtask

  task automatic core_op(input bit st, input logic [6:0] a, input logic [31:0] d, output int ns);
    drive_op(st, a, d);
    wait_done(ns);
  endtask

  task automatic idle(input int n);
    CEN = 1; WEN = 1; OEN = 1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain_wait();
    int k = 0;
    CEN = 1; WEN = 1; OEN = 1;
    while (wq.size() != 0 && k < 200) begin @(negedge clk); k++; end
    chk("drain", wq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 0; CEN = 1; WEN = 1; OEN = 1; A = '0; Data2Mem = '0;
    for (int i = 0; i < 128; i++) begin
      mem_arr[i] = $urandom;
      arch[i]    = mem_arr[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", ReadDataMem, 0);
    #1 rst_n = 1;
    @(posedge clk); #1;
    idle(2);

    // single posted store, drained the following cycle
    core_op(1, 7'd5, 32'h1234, n);
    chk("st_nostall", n, 0);
    CEN = 1; WEN = 1; OEN = 1;
    @(negedge clk);
    chk("drain_req", mem_req, 1);
    chk("drain_we", mem_we, 1);
    chk("drain_addr", mem_addr, 5);
    chk("drain_wdata", mem_wdata, 32'h1234);
    @(negedge clk);
    chk("drain_empty", mem_req, 0);
    @(posedge clk); #1;

    // fill the buffer with memory blocked; fifth store waits for a freed slot
    rdy_mode = 0;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      core_op(1, 7'(i), 32'h100 + i, n);
      chk("fill_nostall", n, 0);
    end
    drive_op(1, 7'd4, 32'h104);
    @(negedge clk);
    chk("full_stall", stall, 1);
    rdy_mode = 1;
    wait_done(n);
    chk("full_retry_cycles", n, 1);
    drain_wait();

    // two stores to one address, then a load of it
    rdy_mode = 0;
    idle(1);
    core_op(1, 7'd9, 32'hAA, n);
    core_op(1, 7'd9, 32'hBB, n);
`ifndef WBUF_FWD_EN
    rdy_mode = 1;
`endif
    core_op(0, 7'd9, 32'h0, n);
`ifdef WBUF_FWD_EN
    chk("fwd_nostall", n, 0);
`endif
    rdy_mode = 1;
    drain_wait();

    // minimum-latency load miss
    mem_arr[3] = 32'hDEADBEEF;
    arch[3]    = 32'hDEADBEEF;
    rv_delay   = 1;
    core_op(0, 7'd3, 32'h0, n);
    chk("miss_stall_cycles", n, 3);

    // load with stores pending while memory is blocked for three cycles
    rdy_mode = 0;
    idle(1);
    core_op(1, 7'd40, $urandom, n);
    core_op(1, 7'd41, $urandom, n);
    drive_op(0, 7'd7, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("ld7_stall_hold", stall, 1);
    end
    rdy_mode = 1;
    wait_done(n);
`ifdef WBUF_FWD_EN
    chk("ld7_stall_cycles", n, 2);
`else
    chk("ld7_stall_cycles", n, 5);
`endif
    drain_wait();

    // reset while waiting for read data
    rdy_mode = 0;
    idle(1);
    core_op(1, 7'd50, $urandom, n);
    core_op(1, 7'd51, $urandom, n);
    drive_op(0, 7'd60, 32'h0);
    rv_delay = 3;
    rdy_mode = 1;
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      found = mem_req && !mem_we && mem_ready;
    end
    chk("rd_issue_seen", found, 1);
    @(posedge clk); #1;
    rst_n = 0; CEN = 1; WEN = 1; OEN = 1;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_stall", stall, 0);
    chk("arst_rdata", ReadDataMem, 0);
    lq.delete();
    wq.delete();
    for (int i = 0; i < 128; i++) arch[i] = mem_arr[i];
    @(negedge clk);
    #1 rst_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_req", mem_req, 0);
      chk("post_rst_stall", stall, 0);
    end
    @(posedge clk); #1;
    rv_delay = 1;

    // randomized traffic over a small address window to provoke hits and overwrites
    rv_rand  = 1;
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [6:0] a;
      r = int'($urandom_range(0, 9));
      a = 7'($urandom_range(0, 11));
      if (r < 4)      core_op(1, a, $urandom, n);
      else if (r < 8) core_op(0, a, 32'h0, n);
      else            idle(1);
    end
    rdy_mode = 1;
    drain_wait();
    idle(4);
    chk("loads_all_done", lq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_write_buffer_bridge.md
Name: dmem_write_buffer_bridge

Overview:
- Sits between the single-cycle core's data-memory port (CEN/WEN/OEN/A/Data2Mem/ReadDataMem) and a variable-latency data memory with a req/ready/rvalid handshake.
- Stores are posted into a small FIFO write buffer, so the core does not stall while the buffer has room.
- Loads are served from the buffer on an address hit. On a miss they are fetched from memory, and the core is held with `stall`.

Parameters:
- DEPTH, 4, write-buffer entries (power of two, >=2)
- AW, 7, word-address width (matches core port A)
- DW, 32, data width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- CEN  in  1  core chip enable, active low
- WEN  in  1  core write enable, active low
- OEN  in  1  core output (read) enable, active low
- A  in  AW  core word address
- Data2Mem  in  DW  core store data
- ReadDataMem  out  DW  load data to core
- stall  out  1  core must hold PC and all memory inputs while high
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_ready  in  1  request accepted when mem_req&&mem_ready
- mem_rvalid  in  1  read data valid (one cycle)
- mem_rdata  in  DW  read data

Behaviour:
- Reset (async, rst_n=0): buffer empty (rd/wr pointers and count=0), FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stall=0, ReadDataMem=0, captured read register=0. Reset mid-transaction abandons it; buffered stores are lost. A late mem_rvalid after reset is ignored.
- Decode:
  - store = !CEN && !WEN
  - load = !CEN && !OEN && WEN
  - WEN=0 and OEN=0 together is treated as a store.
  - CEN=1 means no operation.
- Store:
  - If count<DEPTH, the {A,Data2Mem} entry is enqueued at the clock edge and stall=0.
  - If count==DEPTH, stall=1 and nothing is enqueued. The store is retried each cycle; it is accepted on the first edge where count<DEPTH at the start of the cycle. A same-cycle dequeue does not free a slot early.
- Load hit (WBUF_FWD_EN defined): the youngest valid entry with a matching address drives ReadDataMem combinationally, with stall=0 and zero latency.
- Load miss: stall=1 combinationally. The FSM goes IDLE->RD_REQ:
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=A, held until mem_ready, then ->RD_WAIT.
  - RD_WAIT: on mem_rvalid, capture mem_rdata, ->RD_DONE.
  - RD_DONE: stall=0 and ReadDataMem=captured data for exactly one cycle, then ->IDLE.
  - Minimum load-miss latency is 3 stall cycles with mem_ready=1 and rvalid one cycle after acceptance.
- Drain:
  - In IDLE with count>0 and no load miss pending: mem_req=1, mem_we=1, and the head entry drives mem_addr/mem_wdata.
  - The entry is dequeued on mem_req&&mem_ready.
  - A load miss has priority over drain. A drain request not yet accepted is withdrawn when a load miss appears; a drain accepted in the same cycle completes.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- ReadDataMem is 0 when there is no load and the FSM is not in RD_DONE.
- mem_req never drops before mem_ready, except in the drain-withdrawal case above.

Optional Feature:
- Macro: WBUF_FWD_EN
- Defined: the buffer is searched on loads, and a hit returns the youngest matching data with no stall; a miss bypasses pending stores (safe, because no buffered entry matches).
- Undefined: no search. Any load stalls until count==0 (drain completes), then follows the miss sequence. This guarantees ordering without comparators.

Test Plan:
- Store A=5, D=0x1234 with mem_ready=1 → stall=0; next cycle mem_req=1, mem_we=1, mem_addr=5, mem_wdata=0x1234; count returns to 0.
- mem_ready=0, five consecutive stores to A=0..4 → first four accepted with stall=0; fifth raises stall=1. Raise mem_ready → fifth accepted one cycle after the first dequeue; memory sees addresses 0,1,2,3,4 in order.
- WBUF_FWD_EN defined, mem_ready=0: store A=9 D=0xAA, then A=9 D=0xBB, then load A=9 → ReadDataMem=0xBB in the same cycle, stall=0.
- Load miss A=3 with mem_rdata=0xDEADBEEF, ready=1, rvalid one cycle later → stall high for 3 cycles; 4th cycle stall=0 and ReadDataMem=0xDEADBEEF.
- WBUF_FWD_EN undefined: two stores pending, then load A=7 → stall held until both writes are accepted, then read of address 7 is issued.
- Assert rst_n=0 during RD_WAIT with 2 buffered entries → mem_req=0, stall=0, count=0 immediately; a following rvalid pulse has no effect.
